unified_mem_arbiter: RTL and testbench

//  Shares one single-port unified memory between the IF-stage fetch port and the MEM-stage data port.

---
 rtl/unified_mem_arbiter_if.sv | 38 +++
 rtl/unified_mem_arbiter.sv | 224 ++++++++++++++++++++++
 tb/tb_unified_mem_arbiter.sv | 380 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/unified_mem_arbiter_if.sv
// Memory-side request/response bus shared by the fetch and data ports.
// The arbiter drives it as master; the memory controller is the slave.
interface unified_mem_arbiter_if #(
  parameter int XLEN = 32
);

  logic            mem_valid;
  logic            mem_ready;
  logic            mem_we;
  logic [XLEN-1:0] mem_addr;
  logic [XLEN-1:0] mem_wdata;
  logic [3:0]      mem_byte_en;
  logic            mem_rvalid;
  logic [XLEN-1:0] mem_rdata;

  modport master (
    output mem_valid,
    output mem_we,
    output mem_addr,
    output mem_wdata,
    output mem_byte_en,
    input  mem_ready,
    input  mem_rvalid,
    input  mem_rdata
  );

  modport slave (
    input  mem_valid,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    input  mem_byte_en,
    output mem_ready,
    output mem_rvalid,
    output mem_rdata
  );

endinterface

// File: rtl/unified_mem_arbiter.sv
// Arbitrates IF fetch and MEM data ports onto one single-port memory.
// Data wins by default; a streak counter forces a fetch after a run of data grants.
module unified_mem_arbiter #(
  parameter int XLEN         = 32,
  parameter int STARVE_LIMIT = 4,
  parameter int STREAK_W     = 3
) (
  input  logic            clk,
  input  logic            reset,

  input  logic            if_req,
  input  logic [XLEN-1:0] if_addr,
  input  logic            if_kill,
  output logic [XLEN-1:0] if_rdata,
  output logic            if_ready,
  output logic            if_stall,

  input  logic            dm_req,
  input  logic            dm_we,
  input  logic [XLEN-1:0] dm_addr,
  input  logic [XLEN-1:0] dm_wdata,
  input  logic [3:0]      dm_byte_en,
  output logic [XLEN-1:0] dm_rdata,
  output logic            dm_ready,
  output logic            dm_stall,

  unified_mem_arbiter_if.master mem
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DONE
  } state_t;

  typedef enum logic {
    OWN_DATA,
    OWN_FETCH
  } owner_t;

  localparam logic [STREAK_W-1:0] LIMIT =
    STREAK_W'(STARVE_LIMIT);
  localparam logic [STREAK_W-1:0] ONE =
    STREAK_W'(1);

  state_t state_q;
  state_t state_d;
  owner_t owner_q;

  logic [STREAK_W-1:0] streak_q;
  logic [STREAK_W-1:0] streak_d;
  logic                kill_pend_q;
  logic                kill_pend_d;

  logic            we_q;
  logic [XLEN-1:0] addr_q;
  logic [XLEN-1:0] wdata_q;
  logic [3:0]      be_q;

  logic            req_we;
  logic [XLEN-1:0] req_addr;
  logic [XLEN-1:0] req_wdata;
  logic [3:0]      req_be;

  logic [XLEN-1:0] if_rdata_q;
  logic [XLEN-1:0] dm_rdata_q;

  logic starve;
  logic grant_dm;
  logic grant_if;
  logic granted;
  logic fetch_own;
  logic in_idle;
  logic in_req;
  logic in_done;
  logic rsp_take;

  assign in_idle   = state_q == S_IDLE;
  assign in_req    = state_q == S_REQ;
  assign in_done   = state_q == S_DONE;
  assign fetch_own = owner_q == OWN_FETCH;

  assign starve   = if_req && (streak_q == LIMIT);
  assign grant_dm = dm_req && !starve;
  assign grant_if = !grant_dm && if_req && !if_kill;
  assign granted  = in_idle && (grant_dm || grant_if);

  assign rsp_take = (state_q == S_WAIT) &&
                    mem.mem_rvalid;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (grant_dm || grant_if) begin
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (mem.mem_ready) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (mem.mem_rvalid) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    req_we    = 1'b0;
    req_addr  = if_addr;
    req_wdata = '0;
    req_be    = 4'b1111;
    unique case (1'b1)
      grant_dm: begin
        req_we    = dm_we;
        req_addr  = dm_addr;
        req_wdata = dm_wdata;
        req_be    = dm_we ? dm_byte_en
                          : 4'b1111;
      end
      grant_if: begin
        req_addr = if_addr;
      end
      default: begin
        req_addr = if_addr;
      end
    endcase
  end

  // Streak only counts data grants that overtook a waiting fetch.
  always_comb begin
    streak_d = streak_q;
    if (grant_if || !if_req) begin
      streak_d = '0;
    end else if (grant_dm) begin
      if (streak_q != LIMIT) begin
        streak_d = streak_q + ONE;
      end
    end
  end

  always_comb begin
    kill_pend_d = kill_pend_q;
    if (in_done) begin
      kill_pend_d = 1'b0;
    end else if (!in_idle && fetch_own &&
                 if_kill) begin
      kill_pend_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      streak_q    <= '0;
      kill_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      kill_pend_q <= kill_pend_d;
      if (in_idle) begin
        streak_q <= streak_d;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      owner_q <= OWN_DATA;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
    end else if (granted) begin
      owner_q <= grant_dm ? OWN_DATA
                          : OWN_FETCH;
      we_q    <= req_we;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
      be_q    <= req_be;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
    end else if (rsp_take) begin
      if (fetch_own) begin
        if_rdata_q <= mem.mem_rdata;
      end else begin
        dm_rdata_q <= mem.mem_rdata;
      end
    end
  end

  // Bus fields are zeroed outside REQ so idle cycles present a clean bus.
  assign mem.mem_valid   = in_req;
  assign mem.mem_we      = in_req & we_q;
  assign mem.mem_addr    = in_req ? addr_q  : '0;
  assign mem.mem_wdata   = in_req ? wdata_q : '0;
  assign mem.mem_byte_en = in_req ? be_q    : '0;

  assign if_ready = in_done && fetch_own &&
                    !kill_pend_q && !if_kill;
  assign dm_ready = in_done && !fetch_own;

  assign if_rdata = if_rdata_q;
  assign dm_rdata = dm_rdata_q;

  assign if_stall = if_req && !if_ready;
  assign dm_stall = dm_req && !dm_ready;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Scoreboard bench for unified_mem_arbiter: a memory responder model,
// expected-request and expected-response queues, directed scenarios.
module tb_unified_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_kill;
  logic [31:0] if_rdata;
  logic        if_ready;
  logic        if_stall;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [3:0]  dm_byte_en;
  logic [31:0] dm_rdata;
  logic        dm_ready;
  logic        dm_stall;

  unified_mem_arbiter_if #(.XLEN(32)) mem ();

  unified_mem_arbiter #(
    .XLEN(32),
    .STARVE_LIMIT(4),
    .STREAK_W(3)
  ) dut (
    .clk(clk),
    .reset(reset),
    .if_req(if_req),
    .if_addr(if_addr),
    .if_kill(if_kill),
    .if_rdata(if_rdata),
    .if_ready(if_ready),
    .if_stall(if_stall),
    .dm_req(dm_req),
    .dm_we(dm_we),
    .dm_addr(dm_addr),
    .dm_wdata(dm_wdata),
    .dm_byte_en(dm_byte_en),
    .dm_rdata(dm_rdata),
    .dm_ready(dm_ready),
    .dm_stall(dm_stall),
    .mem(mem)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        chk;
    logic [31:0] data;
  } rsp_t;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } req_t;

  rsp_t if_q[$];
  rsp_t dm_q[$];
  req_t req_q[$];
  logic [31:0] img [logic [31:0]];

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int ready_delay = 0;
  int rvalid_delay = 0;
  int acc_count = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h",
               name, act, exp);
    end
  endtask

  function automatic req_t mk_req(
      input logic we, input logic [31:0] a,
      input logic [31:0] wd, input logic [3:0] be);
    req_t r;
    r.we = we; r.addr = a; r.wdata = wd; r.be = be;
    return r;
  endfunction

  function automatic rsp_t mk_rsp(
      input logic chk, input logic [31:0] d);
    rsp_t r;
    r.chk = chk; r.data = d;
    return r;
  endfunction

  // Memory responder: accepts after ready_delay cycles,
  // answers rvalid_delay cycles after the WAIT state begins.
  initial begin
    logic        busy;
    logic        acc_last;
    logic        holding;
    int          wcnt;
    int          rcnt;
    logic [31:0] rhold;
    req_t        held;
    req_t        e;
    busy = 0; acc_last = 0; holding = 0;
    wcnt = 0; rcnt = 0; rhold = '0; held = '0;
    mem.mem_ready  = 1'b0;
    mem.mem_rvalid = 1'b0;
    mem.mem_rdata  = '0;
    forever begin
      @(negedge clk);
      mem.mem_ready  = 1'b0;
      mem.mem_rvalid = 1'b0;
      if (acc_last) begin
        busy = 1; rcnt = rvalid_delay; acc_last = 0;
      end
      if (busy) begin
        if (rcnt == 0) begin
          mem.mem_rvalid = 1'b1;
          mem.mem_rdata  = rhold;
          busy = 0;
        end else begin
          rcnt--;
        end
      end else if (mem.mem_valid) begin
        if (holding) begin
          check("hold_addr", mem.mem_addr, held.addr);
          check("hold_we", mem.mem_we, held.we);
          check("hold_be", mem.mem_byte_en, held.be);
          check("hold_wdata", mem.mem_wdata, held.wdata);
        end else begin
          held = mk_req(mem.mem_we, mem.mem_addr,
                        mem.mem_wdata, mem.mem_byte_en);
          holding = 1;
        end
        if (wcnt >= ready_delay) begin
          mem.mem_ready = 1'b1;
          acc_last = 1; wcnt = 0; holding = 0;
          acc_count++;
          rhold = img.exists(mem.mem_addr) ?
                  img[mem.mem_addr] : 32'h0;
          if (req_q.size() == 0) begin
            check("unexpected_mem_req",
                  mem.mem_addr, 32'hFFFF_FFFF);
          end else begin
            e = req_q.pop_front();
            check("req_addr", mem.mem_addr, e.addr);
            check("req_we", mem.mem_we, e.we);
            check("req_be", mem.mem_byte_en, e.be);
            if (e.we) check("req_wdata",
                            mem.mem_wdata, e.wdata);
          end
        end else begin
          wcnt++;
        end
      end
    end
  end

  // Response monitor, sampling after each active edge.
  initial begin
    rsp_t r;
    forever begin
      @(posedge clk);
      #1;
      check("if_stall", if_stall, if_req && !if_ready);
      check("dm_stall", dm_stall, dm_req && !dm_ready);
      if (if_ready) begin
        if (if_q.size() == 0) begin
          check("unexpected_if_ready", 1, 0);
        end else begin
          r = if_q.pop_front();
          check("if_rdata", if_rdata, r.data);
        end
      end
      if (dm_ready) begin
        if (dm_q.size() == 0) begin
          check("unexpected_dm_ready", 1, 0);
        end else begin
          r = dm_q.pop_front();
          if (r.chk) check("dm_rdata", dm_rdata, r.data);
        end
      end
    end
  end

  task automatic do_fetch(input logic [31:0] a,
                          input int n,
                          input logic kill_first,
                          output int lat);
    int got = 0;
    int t0;
    lat = -1;
    @(negedge clk);
    if_addr = a; if_req = 1'b1; if_kill = kill_first;
    t0 = cyc;
    for (int i = 0; i < 200 && got < n; i++) begin
      @(negedge clk);
      if_kill = 1'b0;
      if (if_ready) begin
        got++;
        if (lat < 0) lat = cyc - t0;
      end
    end
    if (got < n) check("fetch_timeout", got, n);
    if_req = 1'b0;
  endtask

  task automatic do_data(input logic we,
                         input logic [31:0] a,
                         input logic [31:0] wd,
                         input logic [3:0] be,
                         input int n,
                         output int lat);
    int got = 0;
    int t0;
    lat = -1;
    @(negedge clk);
    dm_we = we; dm_addr = a; dm_wdata = wd;
    dm_byte_en = be; dm_req = 1'b1;
    t0 = cyc;
    for (int i = 0; i < 200 && got < n; i++) begin
      @(negedge clk);
      if (dm_ready) begin
        got++;
        if (lat < 0) lat = cyc - t0;
      end
    end
    if (got < n) check("data_timeout", got, n);
    dm_req = 1'b0; dm_we = 1'b0;
  endtask

  // Issue a fetch and return at the first negedge of its WAIT state.
  task automatic fetch_to_wait(input logic [31:0] a);
    int a0;
    bit seen = 0;
    @(negedge clk);
    if_addr = a; if_req = 1'b1;
    a0 = acc_count;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      #2;
      if (acc_count != a0) seen = 1;
    end
    if (!seen) check("accept_timeout", 0, 1);
    @(negedge clk);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int dlat;
    reset = 1'b1;
    if_req = 0; if_addr = '0; if_kill = 0;
    dm_req = 0; dm_we = 0; dm_addr = '0;
    dm_wdata = '0; dm_byte_en = '0;
    img[32'h100]  = 32'h0050_0093;
    img[32'h104]  = 32'h0000_0013;
    img[32'h108]  = 32'h0010_8093;
    img[32'h200]  = 32'hBAD0_0000;
    img[32'h300]  = 32'hABCD_0001;
    img[32'h304]  = 32'hABCD_0002;
    img[32'h400]  = 32'h1111_1111;
    img[32'h2000] = 32'h1234_5678;

    repeat (3) @(negedge clk);
    check("rst_mem_valid", mem.mem_valid, 0);
    check("rst_mem_we", mem.mem_we, 0);
    check("rst_mem_addr", mem.mem_addr, 0);
    check("rst_mem_wdata", mem.mem_wdata, 0);
    check("rst_mem_be", mem.mem_byte_en, 0);
    check("rst_if_ready", if_ready, 0);
    check("rst_dm_ready", dm_ready, 0);
    check("rst_if_rdata", if_rdata, 0);
    check("rst_dm_rdata", dm_rdata, 0);
    reset = 1'b0;

    // 1: single fetch, minimum latency
    req_q.push_back(mk_req(0, 32'h100, 0, 4'hF));
    if_q.push_back(mk_rsp(1, 32'h0050_0093));
    do_fetch(32'h100, 1, 0, lat);
    check("t1_latency", lat, 3);

    // 2: simultaneous requests, data first
    req_q.push_back(mk_req(0, 32'h2000, 0, 4'hF));
    req_q.push_back(mk_req(0, 32'h104, 0, 4'hF));
    dm_q.push_back(mk_rsp(1, 32'h1234_5678));
    if_q.push_back(mk_rsp(1, 32'h0000_0013));
    fork
      do_data(0, 32'h2000, 0, 4'h0, 1, dlat);
      do_fetch(32'h104, 1, 0, lat);
    join
    check("t2_data_lat", dlat, 3);
    check("t2_fetch_lat", lat, 7);
    @(negedge clk);
    check("t2_dm_rdata_hold", dm_rdata, 32'h1234_5678);

    // 3: starvation guard, 4 data grants then fetch
    for (int i = 0; i < 4; i++)
      req_q.push_back(mk_req(0, 32'h2000, 0, 4'hF));
    req_q.push_back(mk_req(0, 32'h108, 0, 4'hF));
    req_q.push_back(mk_req(0, 32'h2000, 0, 4'hF));
    for (int i = 0; i < 5; i++)
      dm_q.push_back(mk_rsp(1, 32'h1234_5678));
    if_q.push_back(mk_rsp(1, 32'h0010_8093));
    fork
      do_data(0, 32'h2000, 0, 4'h0, 5, dlat);
      do_fetch(32'h108, 1, 0, lat);
    join
    check("t3_fetch_lat", lat, 19);

    // 4: store held through 3 cycles of mem_ready=0
    ready_delay = 3;
    req_q.push_back(mk_req(1, 32'h40,
                           32'hDEAD_BEEF, 4'b0011));
    dm_q.push_back(mk_rsp(0, 32'h0));
    do_data(1, 32'h40, 32'hDEAD_BEEF, 4'b0011, 1, dlat);
    check("t4_store_lat", dlat, 6);
    ready_delay = 0;

    // 5: kill during WAIT, then a normal fetch
    rvalid_delay = 3;
    req_q.push_back(mk_req(0, 32'h200, 0, 4'hF));
    fetch_to_wait(32'h200);
    if_kill = 1'b1; if_req = 1'b0;
    @(negedge clk);
    if_kill = 1'b0;
    repeat (10) @(negedge clk);
    rvalid_delay = 0;
    req_q.push_back(mk_req(0, 32'h300, 0, 4'hF));
    if_q.push_back(mk_rsp(1, 32'hABCD_0001));
    do_fetch(32'h300, 1, 0, lat);
    check("t5_after_kill_lat", lat, 3);

    // kill in IDLE holds off the grant for that cycle
    req_q.push_back(mk_req(0, 32'h304, 0, 4'hF));
    if_q.push_back(mk_rsp(1, 32'hABCD_0002));
    do_fetch(32'h304, 1, 1, lat);
    check("t5_idle_kill_lat", lat, 4);

    // 6: reset during WAIT, late response ignored
    rvalid_delay = 4;
    req_q.push_back(mk_req(0, 32'h400, 0, 4'hF));
    fetch_to_wait(32'h400);
    reset = 1'b1; if_req = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    check("t6_mem_valid", mem.mem_valid, 0);
    check("t6_if_ready", if_ready, 0);
    check("t6_dm_ready", dm_ready, 0);
    repeat (10) @(negedge clk);
    rvalid_delay = 0;
    req_q.push_back(mk_req(0, 32'h2000, 0, 4'hF));
    dm_q.push_back(mk_rsp(1, 32'h1234_5678));
    do_data(0, 32'h2000, 0, 4'h0, 1, dlat);
    check("t6_after_reset_lat", dlat, 3);

    repeat (4) @(negedge clk);
    check("if_q_left", if_q.size(), 0);
    check("dm_q_left", dm_q.size(), 0);
    check("req_q_left", req_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
